// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline control bundle between the ID/EX hazard taps and the stall/flush sequencer.
// The controller uses the slave modport; the pipeline top (or a bench) uses master.
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_busy;
  logic                  branch_taken_ex;

  logic                  pc_write_en;
  logic                  if_id_write_en;
  logic                  id_ex_hold;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  busy_timeout;
  logic [1:0]            ctrl_state;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_mem_read, ex_rd, ex_busy, branch_taken_ex,
    input  pc_write_en, if_id_write_en, id_ex_hold, if_id_flush, id_ex_flush,
    input  busy_timeout, ctrl_state, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_mem_read, ex_rd, ex_busy, branch_taken_ex,
    output pc_write_en, if_id_write_en, id_ex_hold, if_id_flush, id_ex_flush,
    output busy_timeout, ctrl_state, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes, EX holds.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [FW-1:0] FCNT_RELOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_LIMIT  = BW'(BUSY_TIMEOUT);

  state_t          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            timeout_q;

  logic            pc_we, ifid_we, hold, ifid_flush, idex_flush;
  logic            load_use;
  logic [REG_ADDR_W-1:0] rs1_unused_w, rs2_unused_w;

  assign rs1_unused_w = '0;
  assign rs2_unused_w = '0;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != rs1_unused_w) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    hold       = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    bcnt_d     = bcnt_q;

    if (reset) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
      fcnt_d     = '0;
      bcnt_d     = '0;
    end else if (state_q == ST_FLUSH) begin
      // Busy and load-use are ignored while the wrong-path instructions drain.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (hz.branch_taken_ex) begin
        fcnt_d = FCNT_RELOAD;
      end else if (fcnt_q <= FW'(1)) begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q - FW'(1);
      end
    end else if (hz.ex_busy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      hold    = 1'b1;
      state_d = ST_BUSY;
      if (state_q != ST_BUSY) begin
        bcnt_d = BW'(1);
      end else if (bcnt_q != BCNT_LIMIT) begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end else begin
      // RUN, or the cycle BUSY releases: a branch or load-use here is acted on at once.
      state_d = ST_RUN;
      bcnt_d  = '0;
      if (hz.branch_taken_ex) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_RELOAD;
        end
      end else if (load_use) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    fcnt_q  <= fcnt_d;
    bcnt_q  <= bcnt_d;
    if (reset) begin
      timeout_q <= 1'b0;
    end else if ((state_q == ST_BUSY) && (bcnt_q == BCNT_LIMIT)) begin
      timeout_q <= 1'b1;
    end
  end

  assign hz.pc_write_en    = pc_we;
  assign hz.if_id_write_en = ifid_we;
  assign hz.id_ex_hold     = hold;
  assign hz.if_id_flush    = ifid_flush;
  assign hz.id_ex_flush    = idex_flush;
  assign hz.busy_timeout   = timeout_q;
  assign hz.ctrl_state     = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (idex_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_cycles = flush_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (FLUSH_CYCLES=2, BUSY_TIMEOUT=4) with a
// cycle-level reference model and literal spot checks.
module tb_pipeline_hazard_controller;

  localparam int FC = 2;
  localparam int TO = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  pipeline_hazard_controller_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

  pipeline_hazard_controller #(
    .REG_ADDR_W  (5),
    .FLUSH_CYCLES(FC),
    .BUSY_TIMEOUT(TO),
    .CNT_W       (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: extra flush cycles still owed, consecutive busy-stall cycles so far.
  int          m_flush_left = 0;
  int          m_busy_run   = 0;
  logic        m_to         = 1'b0;
  logic [31:0] m_stall      = '0;
  logic [31:0] m_flush      = '0;

  // Expected {pc_write_en, if_id_write_en, id_ex_hold, if_id_flush, id_ex_flush}.
  function automatic logic [4:0] model_ctrl();
    logic lu;
    lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
         ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
    if (reset)                return 5'b00011;
    if (m_flush_left > 0)     return 5'b11011;
    if (hz.ex_busy)           return 5'b00100;
    if (hz.branch_taken_ex)   return 5'b11011;
    if (lu)                   return 5'b00001;
    return 5'b11000;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_flush_left > 0) return 2'd1;
    if (m_busy_run > 0)   return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge clk) begin : model_update
    logic [4:0] o;
    o = model_ctrl();
    if (reset) begin
      m_flush_left <= 0;
      m_busy_run   <= 0;
      m_to         <= 1'b0;
      m_stall      <= '0;
      m_flush      <= '0;
    end else begin
      if (m_busy_run >= TO) m_to <= 1'b1;
      if (!o[4]) m_stall <= m_stall + 32'd1;
      if (o[0])  m_flush <= m_flush + 32'd1;
      if (m_flush_left > 0) begin
        m_flush_left <= hz.branch_taken_ex ? FC - 1 : m_flush_left - 1;
        m_busy_run   <= 0;
      end else if (hz.ex_busy) begin
        m_busy_run <= m_busy_run + 1;
      end else begin
        m_busy_run <= 0;
        if (hz.branch_taken_ex) m_flush_left <= FC - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ctrl_vs_model",
            64'({hz.pc_write_en, hz.if_id_write_en, hz.id_ex_hold, hz.if_id_flush, hz.id_ex_flush}),
            64'(model_ctrl()));
      check("state_vs_model", 64'(hz.ctrl_state), 64'(model_state()));
      check("timeout_vs_model", 64'(hz.busy_timeout), 64'(m_to));
`ifdef HAZARD_PERF_EN
      check("stall_cnt_vs_model", 64'(hz.stall_cycles), 64'(m_stall));
      check("flush_cnt_vs_model", 64'(hz.flush_cycles), 64'(m_flush));
`else
      check("stall_cnt_tied", 64'(hz.stall_cycles), 64'd0);
      check("flush_cnt_tied", 64'(hz.flush_cycles), 64'd0);
`endif
    end
  end

  task automatic apply(input logic r, input logic busy, input logic br, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    @(posedge clk);
    #1;
    reset              = r;
    hz.ex_busy         = busy;
    hz.branch_taken_ex = br;
    hz.ex_mem_read     = mr;
    hz.ex_rd           = rd;
    hz.id_rs1          = rs1;
    hz.id_uses_rs1     = u1;
    hz.id_rs2          = rs2;
    hz.id_uses_rs2     = u2;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Compare the packed control outputs and state against hand-computed literals.
  task automatic expect_ctrl(input string name, input logic [4:0] exp, input logic [1:0] st);
    @(negedge clk);
    check(name, 64'({hz.pc_write_en, hz.if_id_write_en, hz.id_ex_hold, hz.if_id_flush, hz.id_ex_flush}),
          64'(exp));
    check({name, "_state"}, 64'(hz.ctrl_state), 64'(st));
  endtask

  initial begin
    reset = 1'b1;
    hz.ex_busy = 1'b0; hz.branch_taken_ex = 1'b0; hz.ex_mem_read = 1'b0; hz.ex_rd = '0;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    expect_ctrl("reset_outputs", 5'b00011, 2'd0);
    check("reset_timeout", 64'(hz.busy_timeout), 64'd0);

    idle();                                                        expect_ctrl("idle", 5'b11000, 2'd0);

    // Load-use through rs1: one bubble, then the EX bubble removes the hazard.
    apply(0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);                     expect_ctrl("lu_rs1", 5'b00001, 2'd0);
    idle();                                                        expect_ctrl("lu_release", 5'b11000, 2'd0);
    apply(0, 0, 0, 1, 5'd7, 5'd1, 0, 5'd7, 1);                     expect_ctrl("lu_rs2", 5'b00001, 2'd0);
    apply(0, 0, 0, 1, 5'd5, 5'd5, 0, 5'd0, 0);                     expect_ctrl("lu_src_unused", 5'b11000, 2'd0);
    apply(0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);                     expect_ctrl("lu_x0", 5'b11000, 2'd0);

    // Taken branch: two flush cycles, state RUN -> FLUSH -> RUN.
    apply(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("br_cycle1", 5'b11011, 2'd0);
    idle();                                                        expect_ctrl("br_cycle2", 5'b11011, 2'd1);
    idle();                                                        expect_ctrl("br_done", 5'b11000, 2'd0);

    // Branch with load-use: flush wins, then load-use ignored during FLUSH.
    apply(0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);                     expect_ctrl("br_over_lu", 5'b11011, 2'd0);
    apply(0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);                     expect_ctrl("flush_ignores_lu", 5'b11011, 2'd1);
    idle();                                                        expect_ctrl("br_lu_done", 5'b11000, 2'd0);

    // Busy beats branch for 3 cycles; the branch acts the cycle busy drops.
    apply(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("busy_br1", 5'b00100, 2'd0);
    apply(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("busy_br2", 5'b00100, 2'd2);
    apply(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("busy_br3", 5'b00100, 2'd2);
    apply(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("busy_drop_br", 5'b11011, 2'd2);
    idle();                                                        expect_ctrl("busy_br_flush2", 5'b11011, 2'd1);
    idle();                                                        expect_ctrl("busy_br_done", 5'b11000, 2'd0);

    // Load-use present on the cycle busy releases is stalled immediately.
    apply(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("busy_lu1", 5'b00100, 2'd0);
    apply(0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);                     expect_ctrl("busy_drop_lu", 5'b00001, 2'd2);
    idle();                                                        expect_ctrl("busy_lu_done", 5'b11000, 2'd0);
    check("no_timeout_yet", 64'(hz.busy_timeout), 64'd0);

    // Timeout: busy_cnt reaches 4 in the 5th busy cycle, flag visible from the 6th.
    for (int i = 1; i <= 6; i++) begin
      apply(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
      @(negedge clk);
      check($sformatf("timeout_busy%0d", i), 64'(hz.busy_timeout), (i == 6) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      check($sformatf("timeout_sticky%0d", i), 64'(hz.busy_timeout), 64'd1);
    end

    // Reset in the middle of a FLUSH sequence.
    apply(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("rst_br", 5'b11011, 2'd0);
    apply(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);                     expect_ctrl("rst_in_flush", 5'b00011, 2'd1);
    idle();                                                        expect_ctrl("after_rst", 5'b11000, 2'd0);
    check("after_rst_timeout", 64'(hz.busy_timeout), 64'd0);
    check("after_rst_stall_cnt", 64'(hz.stall_cycles), 64'd0);
    check("after_rst_flush_cnt", 64'(hz.flush_cycles), 64'd0);

    // Mixed patterns, checked against the model only.
    for (int i = 0; i < 48; i++) begin
      apply(0, (i % 11) >= 8, (i % 7) == 3, (i % 3) != 0, 5'((i >> 2) % 4),
            5'(i % 4), i[0], 5'((i >> 1) % 4), i[1]);
    end
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
